// File: rtl/rect_mult_pkg.sv
// ---------------------------------------------------------------------------
// rect_mult_pkg
// Shared sizing helpers for the rectangular-tile multiplier.
//   ceil_div(a,b)               : integer ceiling division
//   tile_w(idx,n,tile,width)    : width of tile idx out of n tiles; only the
//                                 last tile can be narrower than 'tile'
//   DEF_TILE_X / DEF_TILE_Y     : 18x24 tiles, one DSP multiplier each
//   NX / NY                     : tile counts for the default 256x256 build
// Ports: none (package).
// ---------------------------------------------------------------------------
package rect_mult_pkg;

  localparam int DEF_WIDTH_X = 256;
  localparam int DEF_WIDTH_Y = 256;
  localparam int DEF_TILE_X  = 18;
  localparam int DEF_TILE_Y  = 24;
  localparam int DEF_TAG_W   = 8;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int tile_w(input int idx, input int n, input int tile, input int width);
    return (idx == n - 1) ? (width - idx * tile) : tile;
  endfunction

  localparam int NX = ceil_div(DEF_WIDTH_X, DEF_TILE_X);
  localparam int NY = ceil_div(DEF_WIDTH_Y, DEF_TILE_Y);

endpackage

// File: rtl/rect_tile_row.sv
// ---------------------------------------------------------------------------
// rect_tile_row
// One Y-tile slice of the multiplier: S1 registers every X-tile times the
// Y slice, S2 registers the shifted sum of those products (the row).
// Ports:
//   clock    in   rising-edge clock
//   en1      in   S1 advance (tile product registers load)
//   en2      in   S2 advance (row register loads)
//   X        in   WIDTH_X  full multiplicand
//   y_slice  in   WY       this row's Y tile
//   row      out  WIDTH_X+WY  registered sum_i tp[i] << (i*TILE_X)
// Data registers carry no reset; validity is tracked by the parent.
// ---------------------------------------------------------------------------
module rect_tile_row
  import rect_mult_pkg::*;
#(
  parameter int WIDTH_X = DEF_WIDTH_X,
  parameter int TILE_X  = DEF_TILE_X,
  parameter int WY      = DEF_TILE_Y
) (
  input  logic                  clock,
  input  logic                  en1,
  input  logic                  en2,
  input  logic [WIDTH_X-1:0]    X,
  input  logic [WY-1:0]         y_slice,
  output logic [WIDTH_X+WY-1:0] row
);

  localparam int L_NX = ceil_div(WIDTH_X, TILE_X);
  localparam int RW   = WIDTH_X + WY;

  logic [RW-1:0] w_tp_ext [L_NX];
  logic [RW-1:0] w_sum;

  for (genvar i = 0; i < L_NX; i++) begin : g_tile
    localparam int WXI = tile_w(i, L_NX, TILE_X, WIDTH_X);
    localparam int PWI = WXI + WY;

    logic [WXI-1:0] w_xs;
    logic [PWI-1:0] r_tp;

    assign w_xs = X[i*TILE_X +: WXI];

    // Both operands widened to the full product width so a narrow edge
    // tile keeps every bit of its product.
    always_ff @(posedge clock) begin
      if (en1) r_tp <= {{WY{1'b0}}, w_xs} * {{WXI{1'b0}}, y_slice};
    end

    assign w_tp_ext[i] = RW'(r_tp) << (i * TILE_X);
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < L_NX; i++) w_sum = w_sum + w_tp_ext[i];
  end

  always_ff @(posedge clock) begin
    if (en2) row <= w_sum;
  end

endmodule

// File: rtl/rect_tile_mult_pipe.sv
// ---------------------------------------------------------------------------
// rect_tile_mult_pipe
// Unsigned pipelined multiplier P = X * Y built from TILE_X x TILE_Y tile
// products. Three register stages (tile products, row sums, final P) with
// valid/ready backpressure and one result per cycle when not stalled.
// Optional sideband tag travels with each operation when RECT_MULT_TAG_EN
// is defined; without it the tag ports and registers do not exist.
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready is combinational
//                         from out_ready through the stall chain)
//   X, Y                  operands
//   in_tag                sideband tag in   (RECT_MULT_TAG_EN only)
//   out_valid / out_ready output handshake
//   P                     full WIDTH_X+WIDTH_Y product, registered
//   out_tag               sideband tag out  (RECT_MULT_TAG_EN only)
// ---------------------------------------------------------------------------
module rect_tile_mult_pipe
  import rect_mult_pkg::*;
#(
  parameter int WIDTH_X = DEF_WIDTH_X,
  parameter int WIDTH_Y = DEF_WIDTH_Y,
  parameter int TILE_X  = DEF_TILE_X,
  parameter int TILE_Y  = DEF_TILE_Y,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_X-1:0]         X,
  input  logic [WIDTH_Y-1:0]         Y,
`ifdef RECT_MULT_TAG_EN
  input  logic [TAG_W-1:0]           in_tag,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_X+WIDTH_Y-1:0] P
`ifdef RECT_MULT_TAG_EN
  ,
  output logic [TAG_W-1:0]           out_tag
`endif
);

  localparam int L_NY = ceil_div(WIDTH_Y, TILE_Y);
  localparam int PW   = WIDTH_X + WIDTH_Y;

  logic r_v1, r_v2, r_v3;
  logic w_adv1, w_adv2, w_adv3;

  // A stage may advance when it is empty or the stage after it advances.
  assign w_adv3    = !r_v3 || out_ready;
  assign w_adv2    = !r_v2 || w_adv3;
  assign w_adv1    = !r_v1 || w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_v3;

  logic [PW-1:0] w_row_ext [L_NY];
  logic [PW-1:0] w_sum;

  for (genvar j = 0; j < L_NY; j++) begin : g_row
    localparam int WYJ = tile_w(j, L_NY, TILE_Y, WIDTH_Y);

    logic [WIDTH_X+WYJ-1:0] w_row;

    rect_tile_row #(
      .WIDTH_X (WIDTH_X),
      .TILE_X  (TILE_X),
      .WY      (WYJ)
    ) u_row (
      .clock   (clock),
      .en1     (w_adv1),
      .en2     (w_adv2),
      .X       (X),
      .y_slice (Y[j*TILE_Y +: WYJ]),
      .row     (w_row)
    );

    assign w_row_ext[j] = PW'(w_row) << (j * TILE_Y);
  end

  always_comb begin
    w_sum = '0;
    for (int j = 0; j < L_NY; j++) w_sum = w_sum + w_row_ext[j];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      P    <= '0;
    end else begin
      if (w_adv1) r_v1 <= in_valid;
      if (w_adv2) r_v2 <= r_v1;
      if (w_adv3) begin
        r_v3 <= r_v2;
        P    <= w_sum;
      end
    end
  end

`ifdef RECT_MULT_TAG_EN
  logic [TAG_W-1:0] r_tag1, r_tag2;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tag1  <= '0;
      r_tag2  <= '0;
      out_tag <= '0;
    end else begin
      if (w_adv1) r_tag1  <= in_tag;
      if (w_adv2) r_tag2  <= r_tag1;
      if (w_adv3) out_tag <= r_tag2;
    end
  end
`endif

endmodule
